// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath (master) and the controller (slave).
interface multicycle_ctrl_if;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [SEL_W-1:0]   regdst;
  logic [SEL_W-1:0]   memtoreg;
  logic               alusrca;
  logic [SEL_W-1:0]   alusrcb;
  logic [SEL_W-1:0]   aluop;
  logic [SEL_W-1:0]   pcsrc;
  logic [STATE_W-1:0] state;
  logic               illegal_op;
  logic               mem_err;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output op, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
           regdst, memtoreg, alusrca, alusrcb, aluop, pcsrc, state, illegal_op,
           mem_err, instr_count
  );

  modport slave (
    input  op, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
           regdst, memtoreg, alusrca, alusrcb, aluop, pcsrc, state, illegal_op,
           mem_err, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller with memory-wait timeout and retired-instruction count.
// Optional feature: define MULTICYCLE_CTRL_JAL_EN to support jal (op 000011) via the JAL state.
// Control outputs are decoded combinationally from the current state (and mem_ready).
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_ctrl_if.slave bus
);
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
`ifdef MULTICYCLE_CTRL_JAL_EN
    S_JAL    = 4'd12,
`endif
    S_ERR    = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               retire;
  logic               timeout;

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next state and control decode; a ready in the final wait cycle beats the timeout.
  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    timeout           = !bus.mem_ready && (wait_q == WAIT_LIM);
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.regdst        = 2'b00;
    bus.memtoreg      = 2'b00;
    bus.alusrca       = 1'b0;
    bus.alusrcb       = 2'b00;
    bus.aluop         = 2'b00;
    bus.pcsrc         = 2'b00;
    bus.illegal_op    = 1'b0;
    bus.mem_err       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.alusrcb  = 2'b01;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
        else if (timeout)  state_d = S_ERR;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (timeout)  state_d = S_ERR;
      end
      S_MEMWB: begin
        bus.reg_write = 1'b1;
        bus.memtoreg  = 2'b01;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        state_d     = S_RTWB;
      end
      S_RTWB: begin
        bus.reg_write = 1'b1;
        bus.regdst    = 2'b01;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca       = 1'b1;
        bus.aluop         = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pcsrc         = 2'b01;
        state_d           = S_FETCH;
        retire            = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pcsrc    = 2'b10;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_JAL_EN
      S_JAL: begin
        bus.pc_write  = 1'b1;
        bus.pcsrc     = 2'b10;
        bus.reg_write = 1'b1;
        bus.regdst    = 2'b10;
        bus.memtoreg  = 2'b10;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
`endif
      S_ERR: begin
        bus.mem_err = 1'b1;
        state_d     = S_ERR;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter runs only while lingering in a memory state; any state change clears it.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) &&
        (state_d == state_q) && !bus.mem_ready)
      wait_d = wait_q + WAIT_W'(1);
  end

  // Retired-instruction count, wrapping naturally.
  always_comb begin
    instr_count_d = instr_count_q + CNT_W'(retire);
  end

  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (TIMEOUT=16).
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.op = 6'h00;
    do_reset();
    #1;
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL reset_mem_read got %b exp 1", bus.mem_read); end
    checks++; if (bus.instr_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.instr_count); end
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got %b exp 0", bus.mem_err); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    bus.op = 6'b100011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, bus.state, exp_st[i]); end
      checks++; if (bus.reg_write !== (exp_st[i] == 4'd4)) begin errors++; $display("FAIL lw_reg_write[%0d] got %b", i, bus.reg_write); end
      if (i == 4) begin
        checks++; if (bus.memtoreg !== 2'b01) begin errors++; $display("FAIL lw_memtoreg got %b exp 01", bus.memtoreg); end
      end
      if (i < 5) step();
    end
    checks++; if (bus.instr_count !== 32'd1) begin errors++; $display("FAIL lw_count got %0d exp 1", bus.instr_count); end
  endtask

  task automatic test_sw_wait();
    do_reset();
    bus.op = 6'b101011;
    bus.mem_ready = 1'b1;
    step(); step(); step();
    for (int j = 0; j < 4; j++) begin
      bus.mem_ready = (j == 3);
      #1;
      checks++; if (bus.state !== 4'd5 || bus.mem_write !== 1'b1 || bus.iord !== 1'b1)
        begin errors++; $display("FAIL sw_hold[%0d] state %0d mem_write %b iord %b exp 5/1/1", j, bus.state, bus.mem_write, bus.iord); end
      step();
    end
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL sw_done_state got %0d exp 0", bus.state); end
    checks++; if (bus.instr_count !== 32'd1) begin errors++; $display("FAIL sw_count got %0d exp 1", bus.instr_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.op = 6'h00;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (bus.state !== 4'd0 || bus.mem_read !== 1'b1)
        begin errors++; $display("FAIL to_wait[%0d] state %0d mem_read %b exp 0/1", i, bus.state, bus.mem_read); end
      step();
    end
    checks++; if (bus.state !== 4'd15) begin errors++; $display("FAIL to_err_state got %0d exp 15", bus.state); end
    checks++; if (bus.mem_err !== 1'b1 || bus.mem_read !== 1'b0)
      begin errors++; $display("FAIL to_err_out mem_err %b mem_read %b exp 1/0", bus.mem_err, bus.mem_read); end
    bus.mem_ready = 1'b1;
    step(); step();
    checks++; if (bus.state !== 4'd15) begin errors++; $display("FAIL to_err_sticky got %0d exp 15", bus.state); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.state !== 4'd0 || bus.mem_err !== 1'b0 || bus.mem_read !== 1'b1)
      begin errors++; $display("FAIL to_reset state %0d mem_err %b mem_read %b exp 0/0/1", bus.state, bus.mem_err, bus.mem_read); end
  endtask

  task automatic test_timeout_edge();
    do_reset();
    bus.op = 6'h00;
    for (int i = 0; i < 15; i++) step();
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.state !== 4'd0 || bus.ir_write !== 1'b1)
      begin errors++; $display("FAIL edge_last state %0d ir_write %b exp 0/1", bus.state, bus.ir_write); end
    step();
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL edge_ready_wins got %0d exp 1", bus.state); end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.op = 6'b111111;
    bus.mem_ready = 1'b1;
    step();
    #1;
    checks++; if (bus.state !== 4'd1 || bus.illegal_op !== 1'b1)
      begin errors++; $display("FAIL ill_decode state %0d illegal_op %b exp 1/1", bus.state, bus.illegal_op); end
    step();
    checks++; if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0)
      begin errors++; $display("FAIL ill_next state %0d illegal_op %b exp 0/0", bus.state, bus.illegal_op); end
    checks++; if (bus.instr_count !== 32'd0) begin errors++; $display("FAIL ill_count got %0d exp 0", bus.instr_count); end
  endtask

  task automatic test_jal();
    do_reset();
    bus.op = 6'b000011;
    bus.mem_ready = 1'b1;
    step();
    #1;
`ifdef MULTICYCLE_CTRL_JAL_EN
    checks++; if (bus.state !== 4'd1 || bus.illegal_op !== 1'b0)
      begin errors++; $display("FAIL jal_decode state %0d illegal_op %b exp 1/0", bus.state, bus.illegal_op); end
    step();
    checks++; if (bus.state !== 4'd12) begin errors++; $display("FAIL jal_state got %0d exp 12", bus.state); end
    checks++; if (bus.regdst !== 2'b10 || bus.pc_write !== 1'b1 || bus.reg_write !== 1'b1 || bus.memtoreg !== 2'b10)
      begin errors++; $display("FAIL jal_out regdst %b pc_write %b reg_write %b memtoreg %b", bus.regdst, bus.pc_write, bus.reg_write, bus.memtoreg); end
    step();
    checks++; if (bus.state !== 4'd0 || bus.instr_count !== 32'd1)
      begin errors++; $display("FAIL jal_done state %0d count %0d exp 0/1", bus.state, bus.instr_count); end
`else
    checks++; if (bus.state !== 4'd1 || bus.illegal_op !== 1'b1 || bus.reg_write !== 1'b0)
      begin errors++; $display("FAIL jal_off_decode state %0d illegal_op %b reg_write %b exp 1/1/0", bus.state, bus.illegal_op, bus.reg_write); end
    step();
    checks++; if (bus.state !== 4'd0 || bus.reg_write !== 1'b0 || bus.instr_count !== 32'd0)
      begin errors++; $display("FAIL jal_off_next state %0d reg_write %b count %0d exp 0/0/0", bus.state, bus.reg_write, bus.instr_count); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.op = 6'b100011;
    bus.mem_ready = 1'b1;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.state !== 4'd3) begin errors++; $display("FAIL mid_in_memrd got %0d exp 3", bus.state); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.state !== 4'd0 || bus.reg_write !== 1'b0)
        begin errors++; $display("FAIL mid_after[%0d] state %0d reg_write %b exp 0/0", i, bus.state, bus.reg_write); end
      step();
    end
    checks++; if (bus.instr_count !== 32'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.instr_count); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    int         cyc [6];
    int         n;
    logic [31:0] exp_count;
    ops = '{6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b100011, 6'b101011};
    cyc = '{4, 4, 3, 3, 5, 4};
    do_reset();
    exp_count = 32'd0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.op = ops[k];
      n = 0;
      do begin
        if (bus.state === 4'd8) begin
          checks++; if (bus.pc_write_cond !== 1'b1 || bus.pcsrc !== 2'b01 || bus.aluop !== 2'b01)
            begin errors++; $display("FAIL b2b_branch pcwc %b pcsrc %b aluop %b exp 1/01/01", bus.pc_write_cond, bus.pcsrc, bus.aluop); end
        end
        if (bus.state === 4'd7) begin
          checks++; if (bus.reg_write !== 1'b1 || bus.regdst !== 2'b01 || bus.memtoreg !== 2'b00)
            begin errors++; $display("FAIL b2b_rtwb reg_write %b regdst %b memtoreg %b exp 1/01/00", bus.reg_write, bus.regdst, bus.memtoreg); end
        end
        if (bus.state === 4'd11) begin
          checks++; if (bus.pc_write !== 1'b1 || bus.pcsrc !== 2'b10)
            begin errors++; $display("FAIL b2b_jump pc_write %b pcsrc %b exp 1/10", bus.pc_write, bus.pcsrc); end
        end
        step();
        n++;
      end while (bus.state !== 4'd0 && n < 20);
      exp_count = exp_count + 32'd1;
      checks++; if (n !== cyc[k]) begin errors++; $display("FAIL b2b_cycles op %b got %0d exp %0d", ops[k], n, cyc[k]); end
      checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL b2b_count op %b got %0d exp %0d", ops[k], bus.instr_count, exp_count); end
    end
  endtask

  initial begin
    bus.op = 6'h00;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_timeout();
    test_timeout_edge();
    test_illegal();
    test_jal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
